// File: rtl/flash_seq_pkg.sv
// Shared encodings for the NeoGS flash programmer: host command codes, the
// sequencer/bus-cycle state enum and the JEDEC unlock/command constants.
package flash_seq_pkg;

  localparam logic [1:0] CMD_READ       = 2'b00;
  localparam logic [1:0] CMD_PROG       = 2'b01;
  localparam logic [1:0] CMD_SECT_ERASE = 2'b10;
  localparam logic [1:0] CMD_CHIP_ERASE = 2'b11;

  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, STEP, R_SETUP,
    R_PULSE, R_END, POLL_CHK, RECOVER, DONE
  } state_t;

  localparam logic [11:0] JEDEC_A555 = 12'h555;
  localparam logic [11:0] JEDEC_A2AA = 12'h2AA;

  localparam logic [7:0] JEDEC_DAA = 8'hAA;
  localparam logic [7:0] JEDEC_D55 = 8'h55;
  localparam logic [7:0] JEDEC_DA0 = 8'hA0;
  localparam logic [7:0] JEDEC_D80 = 8'h80;
  localparam logic [7:0] JEDEC_D30 = 8'h30;
  localparam logic [7:0] JEDEC_D10 = 8'h10;
  localparam logic [7:0] JEDEC_DF0 = 8'hF0;

  // Index of the final table write: PROG has 4 writes, both erases have 6.
  function automatic logic [2:0] last_step(input logic [1:0] c);
    return (c == CMD_PROG) ? 3'd3 : 3'd5;
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// Single flash bus-cycle engine: one write or read per start, owning all
// strobes and pulse-width counters. fin marks the last cycle of a bus cycle.
module flash_bus_cycle
  import flash_seq_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int WE_CYC = 2,
  parameter int RD_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] a,
  input  logic [7:0]        d,
  output logic              fin,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] f_addr,
  output logic [7:0]        f_dout,
  output logic              f_doe,
  input  logic [7:0]        f_din,
  output logic              romcs_n,
  output logic              memoe_n,
  output logic              memwe_n
);

  localparam int MAXC = (WE_CYC > RD_CYC) ? WE_CYC : RD_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] WE_LAST = CW'(WE_CYC - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYC - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            accept;

  assign fin    = (state_reg == W_HOLD) || (state_reg == R_END);
  // A new cycle may chain directly off the last cycle of the previous one.
  assign accept = start && ((state_reg == IDLE) || fin);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      W_SETUP: begin
        state_next = W_PULSE;
        cnt_next   = '0;
      end
      W_PULSE: begin
        if (cnt_reg == WE_LAST) state_next = W_HOLD;
        else                    cnt_next   = cnt_reg + 1'b1;
      end
      R_SETUP: begin
        state_next = R_PULSE;
        cnt_next   = '0;
      end
      R_PULSE: begin
        if (cnt_reg == RD_LAST) state_next = R_END;
        else                    cnt_next   = cnt_reg + 1'b1;
      end
      default: begin
        if (accept) state_next = rw ? R_SETUP : W_SETUP;
        else        state_next = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      romcs_n   <= 1'b1;
      memoe_n   <= 1'b1;
      memwe_n   <= 1'b1;
      f_doe     <= 1'b0;
      f_addr    <= '0;
      f_dout    <= '0;
      rdata     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      romcs_n   <= !(state_next inside {W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_PULSE});
      memoe_n   <= !(state_next inside {R_SETUP, R_PULSE});
      memwe_n   <= (state_next != W_PULSE);
      f_doe     <= (state_next inside {W_SETUP, W_PULSE, W_HOLD});
      if (accept) begin
        f_addr <= a;
        f_dout <= d;
      end
      if ((state_reg == R_PULSE) && (cnt_reg == RD_LAST)) rdata <= f_din;
    end
  end

endmodule

// File: rtl/flash_prog_seq.sv
// JEDEC command sequencer with DQ7/DQ5 polling for the NeoGS flash programmer.
// Define FLASH_PROG_VERIFY_EN to add a read-back compare after PROG.
module flash_prog_seq
  import flash_seq_pkg::*;
#(
  parameter int ADDR_W   = 19,
  parameter int WE_CYC   = 2,
  parameter int RD_CYC   = 3,
  parameter int POLL_MAX = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] f_addr,
  output logic [7:0]        f_dout,
  output logic              f_doe,
  input  logic [7:0]        f_din,
  output logic              romcs_n,
  output logic              memoe_n,
  output logic              memwe_n
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);

  state_t            state_reg, state_next;
  logic [2:0]        step_reg, step_next;
  logic [1:0]        cmd_reg, cmd_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic [PW-1:0]     poll_reg, poll_next, reads_now;
  logic              dq5_reg, dq5_next;
  logic              err_next;

  logic              start, rw, fin;
  logic [ADDR_W-1:0] bus_a, tbl_a;
  logic [7:0]        bus_d, tbl_d;
  logic [1:0]        tbl_cmd;
  logic [2:0]        tbl_idx;
  logic              exp_dq7, poll_ok, poll_fail;

  flash_bus_cycle #(.ADDR_W(ADDR_W), .WE_CYC(WE_CYC), .RD_CYC(RD_CYC)) u_bus (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .a(bus_a), .d(bus_d),
    .fin(fin), .rdata(rdata), .f_addr(f_addr), .f_dout(f_dout), .f_doe(f_doe),
    .f_din(f_din), .romcs_n(romcs_n), .memoe_n(memoe_n), .memwe_n(memwe_n)
  );

  // Command table: the entry for the write about to be issued.
  always_comb begin
    tbl_cmd = (state_reg == IDLE) ? cmd : cmd_reg;
    tbl_idx = (state_reg == IDLE) ? 3'd0 : step_reg + 3'd1;
    tbl_a   = ADDR_W'(JEDEC_A555);
    tbl_d   = JEDEC_DAA;
    case (tbl_idx)
      3'd1, 3'd4: begin
        tbl_a = ADDR_W'(JEDEC_A2AA);
        tbl_d = JEDEC_D55;
      end
      3'd2: tbl_d = (tbl_cmd == CMD_PROG) ? JEDEC_DA0 : JEDEC_D80;
      3'd3: begin
        if (tbl_cmd == CMD_PROG) begin
          tbl_a = addr_reg;
          tbl_d = wdata_reg;
        end
      end
      3'd5: begin
        if (tbl_cmd == CMD_SECT_ERASE) begin
          tbl_a = addr_reg;
          tbl_d = JEDEC_D30;
        end else begin
          tbl_d = JEDEC_D10;
        end
      end
      default: ;
    endcase
  end

  assign exp_dq7   = (cmd_reg == CMD_PROG) ? wdata_reg[7] : 1'b1;
  assign reads_now = poll_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    cmd_next   = cmd_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    poll_next  = poll_reg;
    dq5_next   = dq5_reg;
    err_next   = err;
    start      = 1'b0;
    rw         = 1'b0;
    bus_a      = tbl_a;
    bus_d      = tbl_d;
    poll_ok    = 1'b0;
    poll_fail  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          cmd_next   = cmd;
          addr_next  = addr;
          wdata_next = wdata;
          err_next   = 1'b0;
          step_next  = 3'd0;
          start      = 1'b1;
          if (cmd == CMD_READ) begin
            rw         = 1'b1;
            bus_a      = addr;
            state_next = R_SETUP;
          end else begin
            state_next = STEP;
          end
        end
      end
      STEP: begin
        if (fin) begin
          start = 1'b1;
          if (step_reg == last_step(cmd_reg)) begin
            rw         = 1'b1;
            bus_a      = addr_reg;
            poll_next  = '0;
            dq5_next   = 1'b0;
            state_next = POLL_CHK;
          end else begin
            step_next = step_reg + 3'd1;
          end
        end
      end
      POLL_CHK: begin
        if (fin) begin
          poll_next = reads_now;
          if (rdata[7] == exp_dq7) begin
            poll_ok = 1'b1;
          end else if (dq5_reg) begin
            poll_fail = 1'b1;
          end else if (rdata[5]) begin
            // DQ5 set: the chip reports a fault, but DQ7 may flip on the next read.
            dq5_next = 1'b1;
            start    = 1'b1;
            rw       = 1'b1;
            bus_a    = addr_reg;
          end else if (reads_now >= POLL_LAST) begin
            poll_fail = 1'b1;
          end else begin
            start = 1'b1;
            rw    = 1'b1;
            bus_a = addr_reg;
          end
          if (poll_ok) begin
`ifdef FLASH_PROG_VERIFY_EN
            if (cmd_reg == CMD_PROG) begin
              start      = 1'b1;
              rw         = 1'b1;
              bus_a      = addr_reg;
              state_next = R_SETUP;
            end else begin
              state_next = DONE;
              err_next   = 1'b0;
            end
`else
            state_next = DONE;
            err_next   = 1'b0;
`endif
          end
          if (poll_fail) begin
            start      = 1'b1;
            rw         = 1'b0;
            bus_a      = '0;
            bus_d      = JEDEC_DF0;
            state_next = RECOVER;
          end
        end
      end
      RECOVER: begin
        if (fin) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      R_SETUP: begin
        // Plain READ, or the PROG read-back when verification is built in.
        if (fin) begin
          state_next = DONE;
          err_next   = (cmd_reg == CMD_PROG) && (rdata != wdata_reg);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      cmd_reg   <= CMD_READ;
      addr_reg  <= '0;
      wdata_reg <= '0;
      poll_reg  <= '0;
      dq5_reg   <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      cmd_reg   <= cmd_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      poll_reg  <= poll_next;
      dq5_reg   <= dq5_next;
      err       <= err_next;
      done      <= (state_next == DONE);
      busy      <= !(state_next inside {IDLE, DONE});
    end
  end

endmodule
